// File: rtl/cam_power_seq.sv
// Camera power-up sequencer: walks the sensor PWDN/RESETB pins through timed
// power, reset and settle phases, then pulses cfg_start to launch SCCB setup.
module cam_power_seq #(
    parameter int CNT_W      = 21,
    parameter int PWDN_CYC   = 301000,
    parameter int RST_CYC    = 101000,
    parameter int SETTLE_CYC = 1004000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic cam_pwdn,
    output logic cam_rst_n,
    output logic cfg_start,
    output logic seq_done,
    output logic busy
);

    typedef enum logic [2:0] {
        S_PWDN     = 3'd0,
        S_RST_HOLD = 3'd1,
        S_SETTLE   = 3'd2,
        S_START    = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    // Terminal counts at counter width; N <= 2^CNT_W so N-1 always fits.
    localparam logic [CNT_W-1:0] PWDN_LAST   = CNT_W'(PWDN_CYC - 1);
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_PWDN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        if (restart) begin
            state_nxt = S_PWDN;
        end else begin
            case (state)
                S_PWDN: begin
                    if (cnt == PWDN_LAST) state_nxt = S_RST_HOLD;
                    else                  cnt_nxt   = cnt + CNT_W'(1);
                end
                S_RST_HOLD: begin
                    if (cnt == RST_LAST) state_nxt = S_SETTLE;
                    else                 cnt_nxt   = cnt + CNT_W'(1);
                end
                S_SETTLE: begin
                    if (cnt == SETTLE_LAST) state_nxt = S_START;
                    else                    cnt_nxt   = cnt + CNT_W'(1);
                end
                S_START: state_nxt = S_DONE;
                S_DONE:  state_nxt = S_DONE;
                default: state_nxt = S_PWDN;
            endcase
        end
    end

    // Outputs decode registered state only, so restart never reaches a pin combinationally.
    always_comb begin
        cam_pwdn  = 1'b1;
        cam_rst_n = 1'b0;
        cfg_start = 1'b0;
        seq_done  = 1'b0;
        busy      = 1'b1;
        case (state)
            S_PWDN: begin
                cam_pwdn  = 1'b1;
                cam_rst_n = 1'b0;
            end
            S_RST_HOLD: begin
                cam_pwdn  = 1'b0;
                cam_rst_n = 1'b0;
            end
            S_SETTLE: begin
                cam_pwdn  = 1'b0;
                cam_rst_n = 1'b1;
            end
            S_START: begin
                cam_pwdn  = 1'b0;
                cam_rst_n = 1'b1;
                cfg_start = 1'b1;
            end
            S_DONE: begin
                cam_pwdn  = 1'b0;
                cam_rst_n = 1'b1;
                seq_done  = 1'b1;
                busy      = 1'b0;
            end
            default: begin
                cam_pwdn  = 1'b1;
                cam_rst_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cam_power_seq.sv
// Directed bench for cam_power_seq: short delays (4/3/5) on the main instance,
// minimum delays (1/1/1) on a second instance.
module tb_cam_power_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic restart = 1'b0;
    logic rst2 = 1'b1;
    logic restart2 = 1'b0;

    logic cam_pwdn, cam_rst_n, cfg_start, seq_done, busy;
    logic cam_pwdn2, cam_rst_n2, cfg_start2, seq_done2, busy2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cam_power_seq #(
        .CNT_W(21), .PWDN_CYC(4), .RST_CYC(3), .SETTLE_CYC(5)
    ) dut (
        .clk(clk), .rst(rst), .restart(restart),
        .cam_pwdn(cam_pwdn), .cam_rst_n(cam_rst_n), .cfg_start(cfg_start),
        .seq_done(seq_done), .busy(busy)
    );

    cam_power_seq #(
        .CNT_W(21), .PWDN_CYC(1), .RST_CYC(1), .SETTLE_CYC(1)
    ) dut_min (
        .clk(clk), .rst(rst2), .restart(restart2),
        .cam_pwdn(cam_pwdn2), .cam_rst_n(cam_rst_n2), .cfg_start(cfg_start2),
        .seq_done(seq_done2), .busy(busy2)
    );

    // Expected {pwdn, rst_n, cfg_start, seq_done, busy} for cycle c after release.
    function automatic logic [4:0] model(input int c, input int p, input int r, input int s);
        if (c < p)                  return 5'b10001;
        else if (c < p + r)         return 5'b00001;
        else if (c < p + r + s)     return 5'b01001;
        else if (c == p + r + s)    return 5'b01101;
        else                        return 5'b01010;
    endfunction

    // Outputs seen on a negedge belong to the cycle whose edge comes next.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] obs;
        restart = 1'b0;
        rst = 1'b1;
        step();
        step();
        obs = {cam_pwdn, cam_rst_n, cfg_start, seq_done, busy};
        n_checks++;
        if (obs !== 5'b10001) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected %b", obs, 5'b10001);
        end
        n_checks++;
        if (dut.cnt !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %0d expected 0", dut.cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_power_up();
        logic [4:0] obs;
        apply_reset();
        for (int c = 0; c <= 12; c++) begin
            obs = {cam_pwdn, cam_rst_n, cfg_start, seq_done, busy};
            n_checks++;
            if (obs !== model(c, 4, 3, 5)) begin
                n_fail++;
                $display("FAIL power_up cycle %0d: got %b expected %b", c, obs, model(c, 4, 3, 5));
            end
            step();
        end
        for (int j = 0; j <= 100; j++) begin
            obs = {cam_pwdn, cam_rst_n, cfg_start, seq_done, busy};
            n_checks++;
            if (obs !== 5'b01010) begin
                n_fail++;
                $display("FAIL done_hold cycle %0d: got %b expected %b", 13 + j, obs, 5'b01010);
            end
            step();
        end
    endtask

    task automatic test_restart_done();
        logic [4:0] obs;
        restart = 1'b1;
        step();
        restart = 1'b0;
        for (int j = 0; j <= 13; j++) begin
            obs = {cam_pwdn, cam_rst_n, cfg_start, seq_done, busy};
            n_checks++;
            if (obs !== model(j, 4, 3, 5)) begin
                n_fail++;
                $display("FAIL restart_done k+%0d: got %b expected %b", j + 1, obs, model(j, 4, 3, 5));
            end
            step();
        end
    endtask

    task automatic test_restart_hold();
        logic [4:0] obs;
        restart = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            n_checks++;
            if (cam_pwdn !== 1'b1 || dut.cnt !== 21'd0) begin
                n_fail++;
                $display("FAIL restart_hold k+%0d: got pwdn=%b cnt=%0d expected pwdn=1 cnt=0",
                         i, cam_pwdn, dut.cnt);
            end
        end
        restart = 1'b0;
        for (int j = 0; j <= 13; j++) begin
            obs = {cam_pwdn, cam_rst_n, cfg_start, seq_done, busy};
            n_checks++;
            if (obs !== model(j, 4, 3, 5)) begin
                n_fail++;
                $display("FAIL restart_release +%0d: got %b expected %b", j, obs, model(j, 4, 3, 5));
            end
            step();
        end
    endtask

    task automatic test_restart_settle();
        logic [4:0] obs;
        apply_reset();
        for (int c = 0; c <= 9; c++) begin
            obs = {cam_pwdn, cam_rst_n, cfg_start, seq_done, busy};
            n_checks++;
            if (obs !== model(c, 4, 3, 5)) begin
                n_fail++;
                $display("FAIL settle_pre cycle %0d: got %b expected %b", c, obs, model(c, 4, 3, 5));
            end
            if (c == 9) restart = 1'b1;
            step();
        end
        restart = 1'b0;
        for (int j = 0; j <= 13; j++) begin
            obs = {cam_pwdn, cam_rst_n, cfg_start, seq_done, busy};
            n_checks++;
            if (obs !== model(j, 4, 3, 5)) begin
                n_fail++;
                $display("FAIL settle_restart cycle %0d: got %b expected %b", 10 + j, obs, model(j, 4, 3, 5));
            end
            step();
        end
    endtask

    task automatic test_rst_mid();
        logic [4:0] obs;
        for (int pass = 0; pass < 2; pass++) begin
            apply_reset();
            // pass 0 interrupts RST_HOLD (cycle 5), pass 1 interrupts START (cycle 12)
            for (int c = 0; c < (pass == 0 ? 5 : 12); c++) step();
            if (pass == 1) begin
                n_checks++;
                if (cfg_start !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rst_start_pre: got cfg_start=%b expected 1", cfg_start);
                end
            end
            rst = 1'b1;
            step();
            obs = {cam_pwdn, cam_rst_n, cfg_start, seq_done, busy};
            n_checks++;
            if (obs !== 5'b10001 || dut.cnt !== 21'd0) begin
                n_fail++;
                $display("FAIL rst_mid pass %0d: got %b cnt=%0d expected 10001 cnt=0", pass, obs, dut.cnt);
            end
            rst = 1'b0;
            for (int c = 0; c <= 14; c++) begin
                obs = {cam_pwdn, cam_rst_n, cfg_start, seq_done, busy};
                n_checks++;
                if (obs !== model(c, 4, 3, 5)) begin
                    n_fail++;
                    $display("FAIL rst_replay pass %0d cycle %0d: got %b expected %b",
                             pass, c, obs, model(c, 4, 3, 5));
                end
                step();
            end
        end
    endtask

    task automatic test_min_params();
        logic [4:0] obs;
        restart2 = 1'b0;
        rst2 = 1'b1;
        step();
        rst2 = 1'b0;
        for (int c = 0; c <= 6; c++) begin
            obs = {cam_pwdn2, cam_rst_n2, cfg_start2, seq_done2, busy2};
            n_checks++;
            if (obs !== model(c, 1, 1, 1)) begin
                n_fail++;
                $display("FAIL min_params cycle %0d: got %b expected %b", c, obs, model(c, 1, 1, 1));
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_restart_done();
        test_restart_hold();
        test_restart_settle();
        test_rst_mid();
        test_min_params();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
